arbitrated_stream_mux: RTL and testbench
========================================

ARBITRATED_STREAM_MUX -- requirements
Module: arbitrated_stream_mux

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters (>=2).
REQ-002 Parameter DATA_WIDTH, default 32, is the beat payload width.
REQ-003 clk_i  input  1  is the single clock; all state updates on its rising edge.
REQ-004 arst_ni  input  1  is the asynchronous, active-low reset.
REQ-005 req_valid_i  input  NUM_REQ  carries the per-requester beat valid.
REQ-006 req_data_i  input  NUM_REQ x DATA_WIDTH  carries the per-requester beat payload.
REQ-007 req_last_i  input  NUM_REQ  marks the per-requester final beat of a packet.
REQ-008 req_ready_o  output  NUM_REQ  is the per-requester beat accept; at most one bit high.
REQ-009 out_valid_o  output  1  is the merged stream valid.
REQ-010 out_data_o  output  DATA_WIDTH  is the merged stream payload.
REQ-011 out_last_o  output  1  is the merged stream last flag.
REQ-012 out_idx_o  output  $clog2(NUM_REQ)  is the source requester index of the current output beat.
REQ-013 out_ready_i  input  1  is the downstream accept.
REQ-014 busy_o  output  1  is high while a packet is locked (state LOCKED).

Function
REQ-015 A beat transfers on an input when req_valid_i[i] and req_ready_o[i] are both high, and on the output when out_valid_o and out_ready_i are both high.
REQ-016 The controller has two states, IDLE and LOCKED, plus a rotation pointer rot_ptr of width $clog2(NUM_REQ).
REQ-017 In IDLE, grant goes to the first valid requester searching upward from rot_ptr, wrapping modulo NUM_REQ; if no requester is valid, nothing is granted and out_valid_o is 0.
REQ-018 Arbitration in IDLE is combinational: the granted beat is presented in the same cycle its valid is seen.
REQ-019 In IDLE, a granted beat that is not accepted, or that is accepted with last=0, moves the controller to LOCKED on the granted index.
REQ-020 In IDLE, a granted beat accepted with last=1 keeps the controller in IDLE and sets rot_ptr to (granted index + 1) mod NUM_REQ.
REQ-021 In LOCKED, only the locked index can receive ready or drive the output; the other requesters' req_ready_o bits are 0 regardless of their valid.
REQ-022 In LOCKED, a deasserted valid on the locked requester drives out_valid_o to 0 and keeps the lock (a packet gap).
REQ-023 In LOCKED, acceptance of a beat with last=1 returns the controller to IDLE and sets rot_ptr to (locked index + 1) mod NUM_REQ.
REQ-024 rot_ptr changes only on a last-beat transfer; partial packets and stalls leave it unchanged.
REQ-025 Once out_valid_o is high without out_ready_i, out_data_o, out_last_o and out_idx_o are held stable until the transfer completes.
REQ-026 Without the output register (REQ-031), req_ready_o[g] equals out_ready_i for the granted index g.
REQ-027 The datapath sustains one beat per cycle with no idle cycle between back-to-back packets from different requesters.

Reset
REQ-028 While arst_ni is low: state is IDLE, rot_ptr is 0, req_ready_o is 0, out_valid_o is 0, out_last_o is 0, out_data_o is 0, out_idx_o is 0, and busy_o is 0.
REQ-029 Reset asserted mid-packet abandons the packet; after reset deassertion, arbitration restarts from index 0 with no residual lock.
REQ-030 All requests are gated to zero while arst_ni is low.

Configuration
REQ-031 With ARBITRATED_STREAM_MUX_OUT_REG_EN defined, a single-entry register stage holds out_valid_o, out_data_o, out_last_o and out_idx_o, adding one cycle of latency.
REQ-032 In that registered configuration, the granted req_ready_o equals (register empty OR out_ready_i); throughput stays one beat per cycle; the register is reset empty.
REQ-033 In that registered configuration, the state and rot_ptr update on the input-side transfer, not the output-side transfer.
REQ-034 With ARBITRATED_STREAM_MUX_OUT_REG_EN undefined, the output path is combinational from the inputs and out_ready_i, as in REQ-018 and REQ-026.

Verification
REQ-035 Directed scenario, single beats: after reset, req_valid_i=4'b1111 with all last=1 and out_ready_i=1 for 8 cycles -> out_idx_o sequence is 0,1,2,3,0,1,2,3.
REQ-036 Directed scenario, packet lock: requester 2 sends a 3-beat packet while requester 0 is continuously valid -> beats 2a,2b,2c appear consecutively, req_ready_o[0] stays 0, then requester 0 is granted and rot_ptr is 3.
REQ-037 Directed scenario, backpressure: out_ready_i=0 for 5 cycles with requesters 1 and 3 valid -> out_idx_o=1 and out_data_o remain stable, busy_o=1, and requester 1 transfers when out_ready_i rises.
REQ-038 Directed scenario, gap plus wrap: requester 3 packet with a valid-low gap of 2 cycles mid-packet -> out_valid_o=0 during the gap, lock held, and after last rot_ptr wraps to 0.
REQ-039 Directed scenario, reset mid-packet: arst_ni pulsed low after beat 1 of a 4-beat packet from requester 1 -> all outputs are 0 during reset, and afterwards requester 0 (if valid) wins first.
REQ-040 Directed scenario, build configuration: run REQ-035 with ARBITRATED_STREAM_MUX_OUT_REG_EN defined -> the same index sequence appears, delayed by exactly 1 cycle, with no bubbles.

Source files
------------

// File: rtl/arbitrated_stream_mux.sv
// arbitrated_stream_mux: merges NUM_REQ valid/ready packet streams into one
// output stream. Round-robin arbitration between packets, lock held until the
// last beat of the granted packet transfers.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   arst_ni      asynchronous active-low reset
//   req_valid_i  per-requester beat valid         [NUM_REQ]
//   req_data_i   per-requester beat payload       [NUM_REQ][DATA_WIDTH]
//   req_last_i   per-requester last-beat flag     [NUM_REQ]
//   req_ready_o  per-requester accept, one-hot    [NUM_REQ]
//   out_valid_o  merged stream valid
//   out_data_o   merged stream payload            [DATA_WIDTH]
//   out_last_o   merged stream last flag
//   out_idx_o    source index of current beat     [$clog2(NUM_REQ)]
//   out_ready_i  downstream accept
//   busy_o       high while a packet is locked
//
// Build option: define ARBITRATED_STREAM_MUX_OUT_REG_EN to add a one-entry
// output register (one cycle latency, full throughput).

module arbitrated_stream_mux #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]                  req_last_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic                                out_valid_o,
    output logic [DATA_WIDTH-1:0]               out_data_o,
    output logic                                out_last_o,
    output logic [$clog2(NUM_REQ)-1:0]          out_idx_o,
    input  logic                                out_ready_i,
    output logic                                busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   lock_q, lock_d;
    logic [IDX_W-1:0]   rot_q, rot_d;

    logic [NUM_REQ-1:0] valid_g;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic               sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic               take;
    logic               in_xfer;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Requests are ignored entirely while reset is held.
    assign valid_g = req_valid_i & {NUM_REQ{arst_ni}};

    // Rotating priority search starting at rot_q.
    always_comb begin
        int j;
        j         = 0;
        grant_idx = rot_q;
        grant_hit = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rot_q) + k) % NUM_REQ;
            if (!grant_hit && valid_g[IDX_W'(j)]) begin
                grant_hit = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    assign sel_idx   = (state_q == LOCKED) ? lock_q : grant_idx;
    assign sel_valid = (state_q == LOCKED) ? valid_g[lock_q] : grant_hit;
    assign sel_last  = req_last_i[sel_idx];
    assign sel_data  = req_data_i[sel_idx];
    assign in_xfer   = sel_valid & take;

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            lock_q  <= '0;
            rot_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rot_q   <= rot_d;
        end
    end

    // Next-state logic; driven by the input-side transfer.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rot_d   = rot_q;
        unique case (state_q)
            IDLE: begin
                if (grant_hit) begin
                    if (in_xfer && sel_last) begin
                        rot_d = inc_idx(grant_idx);
                    end else begin
                        state_d = LOCKED;
                        lock_d  = grant_idx;
                    end
                end
            end
            LOCKED: begin
                if (in_xfer && sel_last) begin
                    state_d = IDLE;
                    rot_d   = inc_idx(lock_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ARBITRATED_STREAM_MUX_OUT_REG_EN
    logic                  oreg_valid_q;
    logic [DATA_WIDTH-1:0] oreg_data_q;
    logic                  oreg_last_q;
    logic [IDX_W-1:0]      oreg_idx_q;

    // Register accepts a new beat when empty or draining this cycle.
    assign take = arst_ni & (~oreg_valid_q | out_ready_i);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            oreg_valid_q <= 1'b0;
            oreg_data_q  <= '0;
            oreg_last_q  <= 1'b0;
            oreg_idx_q   <= '0;
        end else if (in_xfer) begin
            oreg_valid_q <= 1'b1;
            oreg_data_q  <= sel_data;
            oreg_last_q  <= sel_last;
            oreg_idx_q   <= sel_idx;
        end else if (out_ready_i) begin
            oreg_valid_q <= 1'b0;
        end
    end
`else
    assign take = arst_ni & out_ready_i;
`endif

    // Output logic.
    always_comb begin
        req_ready_o = '0;
        if (state_q == LOCKED || grant_hit) begin
            req_ready_o[sel_idx] = take;
        end
        busy_o = (state_q == LOCKED);
`ifdef ARBITRATED_STREAM_MUX_OUT_REG_EN
        out_valid_o = oreg_valid_q;
        out_data_o  = oreg_data_q;
        out_last_o  = oreg_last_q;
        out_idx_o   = oreg_idx_q;
`else
        out_valid_o = sel_valid;
        out_data_o  = sel_valid ? sel_data : '0;
        out_last_o  = sel_valid & sel_last;
        out_idx_o   = sel_idx;
`endif
    end

endmodule

// File: tb/tb_arbitrated_stream_mux.sv
// tb_arbitrated_stream_mux: directed self-checking bench for
// arbitrated_stream_mux (NUM_REQ=4, DATA_WIDTH=32).

module tb_arbitrated_stream_mux;

    logic             clk_i = 1'b0;
    logic             arst_ni;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_last;
    logic [3:0]       req_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_last;
    logic [1:0]       out_idx;
    logic             out_ready;
    logic             busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk_i = ~clk_i;

    arbitrated_stream_mux #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_idx_o   (out_idx),
        .out_ready_i (out_ready),
        .busy_o      (busy)
    );

    task automatic test_reset();
        arst_ni   = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = 32'h1000_0000 + 32'(i);
        #2 arst_ni = 1'b0;
        @(negedge clk_i); #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL rst_ready got %b want 0000", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'h0) $display("FAIL rst_data got %h want 0", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_last !== 1'b0) $display("FAIL rst_last got %b want 0", out_last);
        else pass_cnt++;
        total_cnt++;
        if (out_idx !== 2'd0) $display("FAIL rst_idx got %0d want 0", out_idx);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_single_beats();
        for (int c = 0; c < 8; c++) begin
            logic [1:0] e;
            e = 2'(c % 4);
            @(negedge clk_i);
            if (c == 0) arst_ni = 1'b1;
            req_valid = 4'b1111;
            req_last  = 4'b1111;
            out_ready = 1'b1;
            #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== e)
                $display("FAIL single_idx c=%0d got v=%b idx=%0d want v=1 idx=%0d",
                         c, out_valid, out_idx, e);
            else pass_cnt++;
            total_cnt++;
            if (req_ready !== (4'b0001 << e))
                $display("FAIL single_ready c=%0d got %b want %b",
                         c, req_ready, 4'b0001 << e);
            else pass_cnt++;
            total_cnt++;
            if (out_data !== 32'h1000_0000 + 32'(e))
                $display("FAIL single_data c=%0d got %h want %h",
                         c, out_data, 32'h1000_0000 + 32'(e));
            else pass_cnt++;
        end
    endtask

    task automatic test_packet_lock();
        // Single beat from requester 1 moves the pointer to 2.
        @(negedge clk_i);
        req_valid = 4'b0010;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (out_idx !== 2'd1) $display("FAIL lock_pre got %0d want 1", out_idx);
        else pass_cnt++;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk_i);
            req_valid   = 4'b0101;
            req_last    = {1'b1, (b == 2), 1'b1, 1'b1};
            req_data[2] = 32'h2000_00A0 + 32'(b);
            #1;
            total_cnt++;
            if (out_idx !== 2'd2 || out_data !== 32'h2000_00A0 + 32'(b))
                $display("FAIL lock_beat b=%0d got idx=%0d data=%h want idx=2 data=%h",
                         b, out_idx, out_data, 32'h2000_00A0 + 32'(b));
            else pass_cnt++;
            total_cnt++;
            if (req_ready !== 4'b0100)
                $display("FAIL lock_ready b=%0d got %b want 0100", b, req_ready);
            else pass_cnt++;
            total_cnt++;
            if (busy !== (b != 0))
                $display("FAIL lock_busy b=%0d got %b want %b", b, busy, b != 0);
            else pass_cnt++;
        end
        // Pointer is now 3: with 0 and 3 valid, 3 has priority.
        @(negedge clk_i);
        req_valid = 4'b1001;
        req_last  = 4'b1111;
        out_ready = 1'b0;
        #1;
        total_cnt++;
        if (out_idx !== 2'd3) $display("FAIL lock_rot got %0d want 3", out_idx);
        else pass_cnt++;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (out_idx !== 2'd0 || req_ready !== 4'b0001 || busy !== 1'b0)
            $display("FAIL lock_next got idx=%0d rdy=%b busy=%b want 0 0001 0",
                     out_idx, req_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        // Pointer is 1 here.
        req_data[1] = 32'h3000_0001;
        req_data[3] = 32'h3000_0003;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            req_valid = 4'b1010;
            req_last  = 4'b1111;
            out_ready = 1'b0;
            #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 32'h3000_0001)
                $display("FAIL bp_hold c=%0d got v=%b idx=%0d data=%h want 1 1 30000001",
                         c, out_valid, out_idx, out_data);
            else pass_cnt++;
            total_cnt++;
            if (req_ready !== 4'b0000 || busy !== (c != 0))
                $display("FAIL bp_stall c=%0d got rdy=%b busy=%b want 0000 %b",
                         c, req_ready, busy, c != 0);
            else pass_cnt++;
        end
        @(negedge clk_i);
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0010 || out_idx !== 2'd1)
            $display("FAIL bp_release got rdy=%b idx=%0d want 0010 1", req_ready, out_idx);
        else pass_cnt++;
        @(negedge clk_i); #1;
        total_cnt++;
        if (out_idx !== 2'd3 || req_ready !== 4'b1000 || busy !== 1'b0)
            $display("FAIL bp_after got idx=%0d rdy=%b busy=%b want 3 1000 0",
                     out_idx, req_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_gap_wrap();
        // Pointer is 0 here.
        @(negedge clk_i);
        req_valid   = 4'b1000;
        req_last    = 4'b0000;
        req_data[3] = 32'h4000_00A3;
        out_ready   = 1'b1;
        #1;
        total_cnt++;
        if (out_idx !== 2'd3 || req_ready !== 4'b1000 || busy !== 1'b0)
            $display("FAIL gap_first got idx=%0d rdy=%b busy=%b want 3 1000 0",
                     out_idx, req_ready, busy);
        else pass_cnt++;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk_i);
            req_valid = 4'b0001;
            #1;
            total_cnt++;
            if (out_valid !== 1'b0 || busy !== 1'b1 || req_ready[0] !== 1'b0)
                $display("FAIL gap_hold g=%0d got v=%b busy=%b rdy=%b want 0 1 x0",
                         g, out_valid, busy, req_ready);
            else pass_cnt++;
        end
        @(negedge clk_i);
        req_valid   = 4'b1000;
        req_data[3] = 32'h4000_00B3;
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 2'd3 || out_data !== 32'h4000_00B3)
            $display("FAIL gap_mid got v=%b idx=%0d data=%h want 1 3 400000b3",
                     out_valid, out_idx, out_data);
        else pass_cnt++;
        @(negedge clk_i);
        req_last    = 4'b1000;
        req_data[3] = 32'h4000_00C3;
        #1;
        total_cnt++;
        if (out_last !== 1'b1 || out_idx !== 2'd3 || req_ready !== 4'b1000)
            $display("FAIL gap_last got last=%b idx=%0d rdy=%b want 1 3 1000",
                     out_last, out_idx, req_ready);
        else pass_cnt++;
        // Pointer wrapped to 0: 0 beats 3.
        @(negedge clk_i);
        req_valid = 4'b1001;
        req_last  = 4'b1111;
        #1;
        total_cnt++;
        if (out_idx !== 2'd0 || req_ready !== 4'b0001 || busy !== 1'b0)
            $display("FAIL gap_wrap got idx=%0d rdy=%b busy=%b want 0 0001 0",
                     out_idx, req_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_packet();
        // Pointer is 1 here.
        @(negedge clk_i);
        req_valid   = 4'b0011;
        req_last    = 4'b0001;
        req_data[0] = 32'h5000_0000;
        req_data[1] = 32'h5000_0001;
        out_ready   = 1'b1;
        #1;
        total_cnt++;
        if (out_idx !== 2'd1 || req_ready !== 4'b0010)
            $display("FAIL rmp_beat1 got idx=%0d rdy=%b want 1 0010", out_idx, req_ready);
        else pass_cnt++;
        @(negedge clk_i);
        arst_ni = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000 || out_data !== 32'h0
            || out_last !== 1'b0 || out_idx !== 2'd0 || busy !== 1'b0)
            $display("FAIL rmp_in_reset got v=%b rdy=%b d=%h l=%b idx=%0d busy=%b want all 0",
                     out_valid, req_ready, out_data, out_last, out_idx, busy);
        else pass_cnt++;
        @(negedge clk_i);
        arst_ni = 1'b1;
        #1;
        total_cnt++;
        if (out_idx !== 2'd0 || req_ready !== 4'b0001 || busy !== 1'b0
            || out_data !== 32'h5000_0000)
            $display("FAIL rmp_after got idx=%0d rdy=%b busy=%b d=%h want 0 0001 0 50000000",
                     out_idx, req_ready, busy, out_data);
        else pass_cnt++;
        @(negedge clk_i);
        req_valid = 4'b0000;
    endtask

    task automatic test_reg_single_beats();
        for (int c = 0; c < 9; c++) begin
            logic [1:0] g;
            logic [1:0] e;
            g = 2'(c % 4);
            e = 2'((c + 3) % 4);
            @(negedge clk_i);
            if (c == 0) arst_ni = 1'b1;
            req_valid = 4'b1111;
            req_last  = 4'b1111;
            out_ready = 1'b1;
            #1;
            total_cnt++;
            if (req_ready !== (4'b0001 << g))
                $display("FAIL reg_ready c=%0d got %b want %b", c, req_ready, 4'b0001 << g);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== (c != 0))
                $display("FAIL reg_valid c=%0d got %b want %b", c, out_valid, c != 0);
            else pass_cnt++;
            if (c != 0) begin
                total_cnt++;
                if (out_idx !== e)
                    $display("FAIL reg_idx c=%0d got %0d want %0d", c, out_idx, e);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef ARBITRATED_STREAM_MUX_OUT_REG_EN
        test_reg_single_beats();
`else
        test_single_beats();
        test_packet_lock();
        test_backpressure();
        test_gap_wrap();
        test_reset_mid_packet();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
